imem_fetch_arbiter: RTL

Fetch controller and port arbiter for the single-port, combinational-read instruction ROM (8 KiB, 2048 × 32-bit words, word index = address[12:2]). Owns the program counter and produces the registered IF-stage packet (pc, instr, valid). Shares the same ROM port with a data-side read requester (MEM-stage loads from instruction space, e.g. constant tables), with bounded starvation of fetch. Sits between the hazard/branch units and the IF/ID boundary.

---
 rtl/imem_fetch_arbiter_pkg.sv | 13 +
 rtl/imem_port_arb.sv | 62 ++++++
 rtl/imem_fetch_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/imem_fetch_arbiter_pkg.sv
// rtl/imem_fetch_arbiter_pkg.sv - shared constants for the instruction fetch path
package imem_fetch_arbiter_pkg;

    // Byte-address width of the 8 KiB instruction ROM.
    localparam int AW = 13;

    // Default program counter after reset.
    localparam logic [AW-1:0] RESET_PC_DEFAULT = 13'h0000;

    // addi x0, x0, 0 - what the IF stage presents before any real fetch.
    localparam logic [31:0] INSTR_NOP = 32'h00000013;

endpackage

// File: rtl/imem_port_arb.sv
// rtl/imem_port_arb.sv - ROM port arbitration between fetch and data reads
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               IF stage held by the hazard unit
//   redirect_valid      taken branch/jump this cycle
//   dreq_valid          data-side read request
//   dreq_addr           data read byte address (bits [1:0] ignored)
//   pc_q                current fetch PC
//   dgrant              data request owns the ROM port this cycle
//   fetch               fetch owns the ROM port and the IF packet advances
//   rom_addr            word-aligned address driven to the ROM
//   burst_cnt           consecutive data grants that displaced a fetch
module imem_port_arb
    import imem_fetch_arbiter_pkg::*;
#(
    parameter int AW     = imem_fetch_arbiter_pkg::AW,
    parameter int DBURST = 4,
    parameter int CW     = $clog2(DBURST + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic          dreq_valid,
    input  logic [AW-1:0] dreq_addr,
    input  logic [AW-1:0] pc_q,
    output logic          dgrant,
    output logic          fetch,
    output logic [AW-1:0] rom_addr,
    output logic [CW-1:0] burst_cnt
);

    localparam logic [CW-1:0] BURST_MAX = CW'(DBURST);

    // During redirect or stall the fetch slot is wasted anyway, so data
    // requests are always granted then and do not count against the budget.
    always_comb begin
        dgrant   = dreq_valid && (redirect_valid || stall || (burst_cnt < BURST_MAX));
        fetch    = !redirect_valid && !stall && !dgrant;
        rom_addr = dgrant ? (dreq_addr & ~AW'(3)) : pc_q;
    end

    // Counts only grants that actually displaced a fetch; a dropped request
    // resets the budget so an idle requester never starts a burst pre-charged.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (!dreq_valid) begin
            burst_cnt <= '0;
        end else if (redirect_valid || stall) begin
            burst_cnt <= burst_cnt;
        end else if (dgrant) begin
            if (burst_cnt != BURST_MAX) begin
                burst_cnt <= burst_cnt + CW'(1);
            end
        end else begin
            burst_cnt <= '0;
        end
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// rtl/imem_fetch_arbiter.sv - PC owner, IF packet register and shared ROM port
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   stall                          hold PC and IF packet
//   redirect_valid, redirect_pc    flush IF and load a new PC
//   dreq_valid, dreq_addr          data-side ROM read request
//   dreq_ready                     combinational grant for the data request
//   drsp_valid, drsp_data          data response, one cycle after the grant
//   rom_addr, rom_data             single combinational-read ROM port
//   if_valid, if_pc, if_instr      registered IF-stage packet
module imem_fetch_arbiter
    import imem_fetch_arbiter_pkg::*;
#(
    parameter int            AW       = imem_fetch_arbiter_pkg::AW,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT),
    parameter int            DBURST   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          dreq_valid,
    input  logic [AW-1:0] dreq_addr,
    output logic          dreq_ready,
    output logic          drsp_valid,
    output logic [31:0]   drsp_data,
    output logic [AW-1:0] rom_addr,
    input  logic [31:0]   rom_data,
    output logic          if_valid,
    output logic [AW-1:0] if_pc,
    output logic [31:0]   if_instr
);

    localparam int CW = $clog2(DBURST + 1);

    logic [AW-1:0] pc_q;
    logic          dgrant;
    logic          fetch;
    logic [CW-1:0] burst_cnt;

    imem_port_arb #(
        .AW     (AW),
        .DBURST (DBURST),
        .CW     (CW)
    ) u_arb (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .dreq_valid     (dreq_valid),
        .dreq_addr      (dreq_addr),
        .pc_q           (pc_q),
        .dgrant         (dgrant),
        .fetch          (fetch),
        .rom_addr       (rom_addr),
        .burst_cnt      (burst_cnt)
    );

    assign dreq_ready = dgrant;

    // IF packet and PC. Redirect beats stall; a data-displaced fetch only
    // bubbles the packet and leaves the PC where it was.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= INSTR_NOP;
        end else if (redirect_valid) begin
            pc_q     <= redirect_pc & ~AW'(3);
            if_valid <= 1'b0;
        end else if (stall) begin
            pc_q     <= pc_q;
        end else if (fetch) begin
            if_pc    <= pc_q;
            if_instr <= rom_data;
            if_valid <= 1'b1;
            pc_q     <= pc_q + AW'(4);
        end else begin
            if_valid <= 1'b0;
        end
    end

    // Data response: drsp_data keeps the last granted word until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            drsp_valid <= 1'b0;
            drsp_data  <= '0;
        end else begin
            drsp_valid <= dgrant;
            if (dgrant) begin
                drsp_data <= rom_data;
            end
        end
    end

endmodule
